// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner: sync + debounce of set/reset switches driving an SR latch.
// Macro SR_PULSE_EN: one-cycle edge pulses on S/R instead of interlocked levels.
module sr_input_conditioner #(
    parameter int DEBOUNCE_CNT = 50000,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_raw,
    input  logic r_raw,
    output logic S,
    output logic R,
    output logic conflict
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    // Channel index 0 is set, index 1 is reset.
    logic [1:0]       r_meta;
    logic [1:0]       r_sync;
    logic [1:0]       r_stab;
    logic [CNT_W-1:0] r_cnt [2];
    logic             w_s_nxt;
    logic             w_r_nxt;

    // Two-flop synchronizer for both raw switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {r_raw, s_raw};
            r_sync <= r_meta;
        end
    end

    // Per-channel debounce: accept a level after DEBOUNCE_CNT mismatching cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stab <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_stab[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stab[i] <= r_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef SR_PULSE_EN
    logic [1:0] r_hist;
    logic [1:0] w_rise;

    // Rising-edge detect on the debounced levels; reset wins a tie.
    always_comb begin
        w_rise  = r_stab & ~r_hist;
        w_s_nxt = w_rise[0] & ~w_rise[1];
        w_r_nxt = w_rise[1];
    end

    // Edge history of the debounced levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else begin
            r_hist <= r_stab;
        end
    end
`else
    // Interlocked levels: both active means hold (S=0, R=0).
    always_comb begin
        w_s_nxt = r_stab[0] & ~r_stab[1];
        w_r_nxt = r_stab[1] & ~r_stab[0];
    end
`endif

    // Registered outputs to the latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            S        <= w_s_nxt;
            R        <= w_r_nxt;
            conflict <= r_stab[0] & r_stab[1];
        end
    end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb_sr_input_conditioner: scoreboard bench, DEBOUNCE_CNT=8.
// Expected outputs derive from the N+3 edge latency after input change.
module tb_sr_input_conditioner;

    localparam int N = 8;
`ifdef SR_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif
    localparam int LAT = N + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_raw = 1'b0;
    logic r_raw = 1'b0;
    logic S, R, conflict;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [2:0] exp;
    } exp_t;

    exp_t sb [$];

    sr_input_conditioner #(.DEBOUNCE_CNT(N), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_raw    (s_raw),
        .r_raw    (r_raw),
        .S        (S),
        .R        (R),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Push the expectation, advance one edge, pop and compare.
    task automatic step(input string tag, input logic es, input logic er, input logic ec);
        exp_t e;
        sb.push_back('{tag, {es, er, ec}});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, 32'({S, R, conflict}), 32'(e.exp));
        chk("interlock", 32'(S & R), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_raw = 1'b0;
        r_raw = 1'b0;
        #1;
        chk("rst_async", 32'({S, R, conflict}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", 32'({S, R, conflict}), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int cmax;
        int c;

        // Reset state with raws high.
        s_raw = 1'b1;
        r_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init", 32'({S, R, conflict}), 32'd0);

        // Set channel alone: rise then fall.
        do_reset();
        s_raw = 1'b1;
        for (int k = 1; k <= 14; k++)
            step("s_rise", PULSE ? (k == LAT) : (k >= LAT), 1'b0, 1'b0);
        s_raw = 1'b0;
        for (int k = 1; k <= 14; k++)
            step("s_fall", PULSE ? 1'b0 : (k < LAT), 1'b0, 1'b0);

        // Glitch rejection: 5 high, 1 low, four times.
        do_reset();
        cmax = 0;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 6; k++) begin
                s_raw = (k < 5);
                step("glitch", 1'b0, 1'b0, 1'b0);
                c = int'(dut.r_cnt[0]);
                if (c > cmax) cmax = c;
            end
        end
        s_raw = 1'b0;
        for (int k = 0; k < 6; k++)
            step("glitch_tail", 1'b0, 1'b0, 1'b0);
        chk("glitch_cnt_max", 32'(cmax), 32'd5);

        // Both together, then release reset switch.
        do_reset();
        s_raw = 1'b1;
        r_raw = 1'b1;
        for (int k = 1; k <= 14; k++)
            step("both", 1'b0, PULSE ? (k == LAT) : 1'b0, k >= LAT);
        r_raw = 1'b0;
        for (int k = 1; k <= 14; k++)
            step("r_release", PULSE ? 1'b0 : (k >= LAT), 1'b0, k < LAT);

        // Reset channel first, then set rises while reset is held.
        do_reset();
        r_raw = 1'b1;
        for (int k = 1; k <= 14; k++)
            step("r_rise", 1'b0, PULSE ? (k == LAT) : (k >= LAT), 1'b0);
        s_raw = 1'b1;
        for (int k = 1; k <= 14; k++)
            step("s_over_r", PULSE ? (k == LAT) : 1'b0,
                 PULSE ? 1'b0 : (k < LAT), k >= LAT);

        // Reset mid-count discards partial progress.
        do_reset();
        s_raw = 1'b1;
        for (int k = 1; k <= 7; k++)
            step("pre_rst", 1'b0, 1'b0, 1'b0);
        chk("cnt_pre_rst", 32'(dut.r_cnt[0]), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("cnt_in_rst", 32'(dut.r_cnt[0]), 32'd0);
        for (int k = 1; k <= 3; k++)
            step("in_rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++)
            step("post_rst", PULSE ? (k == LAT) : (k >= LAT), 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_input_conditioner.md
SR_INPUT_CONDITIONER -- requirements
Module: sr_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 50000, the number of consecutive agreeing clock cycles needed to accept a new input level (1 ms at 50 MHz); legal range 2 to 65535.
REQ-002 SHALL have parameter CNT_W, default 16, the debounce counter width; DEBOUNCE_CNT SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-005 SHALL have port s_raw, input, 1 bit: raw, asynchronous, bouncing set switch.
REQ-006 SHALL have port r_raw, input, 1 bit: raw, asynchronous, bouncing reset switch.
REQ-007 SHALL have port S, output, 1 bit: conditioned set drive to the downstream SR latch.
REQ-008 SHALL have port R, output, 1 bit: conditioned reset drive to the downstream SR latch.
REQ-009 SHALL have port conflict, output, 1 bit: high while both debounced inputs are active.

Function
REQ-010 SHALL pass each raw input through a two-flop synchronizer; only the second flop output (s_sync, r_sync) feeds later logic.
REQ-011 SHALL keep, per channel, a debounced level (s_stab, r_stab) and a CNT_W-bit counter.
REQ-012 Counter behaviour per channel, each cycle:
- sync equals stab: counter cleared to 0.
- sync differs from stab and counter is below DEBOUNCE_CNT-1: counter increments by 1.
- sync differs from stab and counter equals DEBOUNCE_CNT-1: stab takes the value of sync and the counter clears.
REQ-013 A stab change SHALL require exactly DEBOUNCE_CNT consecutive mismatch cycles; any single-cycle agreement SHALL restart the count from 0, so glitches shorter than DEBOUNCE_CNT cycles are rejected.
REQ-014 The counter SHALL never wrap; it saturates at the DEBOUNCE_CNT-1 boundary by clearing as in REQ-012.
REQ-015 S, R and conflict SHALL be registered outputs driven from stab and from stab-edge state.
REQ-016 Latency: a clean raw step SHALL reach the outputs DEBOUNCE_CNT+3 rising edges after the first edge that samples it (2 synchronizer stages, DEBOUNCE_CNT count cycles, 1 output register).
REQ-017 Interlock: S and R SHALL never both be 1 in the same cycle, so the downstream latch never sees S=1,R=1.
REQ-018 conflict SHALL equal s_stab AND r_stab, registered.
REQ-019 The two channels SHALL debounce independently; the interlock applies only at the output register.

Reset
REQ-020 While rst_n=0, the following SHALL be 0 asynchronously: both synchronizer stages, s_stab, r_stab, both counters, the pulse-edge history, S, R and conflict.
REQ-021 On rst_n deassertion, operation SHALL resume at the next rising clk edge; a raw input already high SHALL then be accepted after the full DEBOUNCE_CNT+3 latency.
REQ-022 A reset mid-count SHALL discard all partial counts; no output pulse SHALL be generated from pre-reset history.

Configuration
REQ-023 Macro SR_PULSE_EN selects the output style.
REQ-024 Without SR_PULSE_EN (level mode):
- S = s_stab AND NOT r_stab.
- R = r_stab AND NOT s_stab.
- Both stab levels high drives S=0, R=0, so the latch holds its state.
REQ-025 With SR_PULSE_EN (pulse mode):
- S pulses high for exactly one cycle on each 0-to-1 transition of s_stab; R does the same for r_stab.
- When both rise in the same cycle, only R pulses (reset priority) and S stays 0.
- A rise on one channel while the other stab is already high still produces its pulse.

Verification
REQ-026 DEBOUNCE_CNT=8, level mode; s_raw held 1 from cycle 0 -> S=1 exactly at edge 11 and R=0 throughout.
REQ-027 DEBOUNCE_CNT=8; s_raw toggles 1 for 5 cycles, then 0 for 1 cycle, repeated 4 times -> S stays 0 and the counter never exceeds 5.
REQ-028 Level mode; s_raw=1 and r_raw=1 both held -> after latency S=0, R=0, conflict=1; releasing r_raw -> S=1, conflict=0 after DEBOUNCE_CNT+3 edges.
REQ-029 SR_PULSE_EN defined; s_raw and r_raw rise in the same cycle and are held -> exactly one R pulse of 1 cycle, S never pulses, conflict=1.
REQ-030 s_raw held 1; rst_n pulled low at count 5 of 8 and released 3 cycles later -> all outputs 0 during reset and S rises 11 edges after release.
